systemizer_ctrl: RTL and testbench

//  Top-level sequencer for the single-pass GF(2) systemizer phase engine. Streams the

---
 rtl/systemizer_pkg.sv | 23 ++
 rtl/systemizer_ctrl_skid_fifo.sv | 44 ++++
 rtl/systemizer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_systemizer_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systemizer_pkg.sv
// Shared types and sizes for the systemizer sequencer.
// Geometry of the GF(2) matrix and the control FSM states.
package systemizer_pkg;

    localparam int M     = 1;
    localparam int N     = 4;
    localparam int L     = 8;
    localparam int K     = 16;
    localparam int NB    = K / N;
    localparam int WORDS = L * K / N;
    localparam int BW    = $clog2(NB + 1);
    localparam int AW    = $clog2(WORDS);
    localparam int W     = N * M;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/systemizer_ctrl_skid_fifo.sv
// Two-entry FIFO that absorbs engine read data while the output stalls.
// The caller guarantees no push when full and no pop when empty.
module sysz_skid_fifo #(
    parameter int DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wp_q;
    logic          rp_q;
    logic [1:0]    cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= !wp_q;
            end
            if (pop_i) begin
                rp_q <= !rp_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o  = mem_q[rp_q];
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/systemizer_ctrl.sv
// Load-run-drain sequencer for the systemizer phase engine.
// Owns the engine memory ports; the host only sees word streams.
module systemizer_ctrl
    import systemizer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_start,
    input  logic [BW-1:0] cmd_block,
    output logic          busy,
    output logic          done,
    output logic          err_block,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          ph_start,
    output logic [BW-1:0] ph_start_block,
    input  logic          ph_done,
    output logic          ph_pk_wr_en,
    output logic [AW-1:0] ph_pk_wr_addr,
    output logic [W-1:0]  ph_pk_din,
    output logic          ph_rd_en,
    output logic [AW-1:0] ph_rd_addr,
    input  logic [W-1:0]  ph_rd_data
);

    localparam logic [BW-1:0] NBLK = BW'(NB);
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wcnt_q, rcnt_q, ocnt_q, wr_addr_q;
    logic [BW-1:0] blk_q;
    logic [W-1:0]  din_q;
    logic          busy_q, done_q, err_q, wr_en_q;
    logic          full_q, rd_all_q, infl_q;
    logic          rd_issue, pop, fifo_valid;
    logic [1:0]    fifo_cnt;
    logic [2:0]    used;

    // A same-cycle pop frees a slot, which keeps drain at one word per cycle.
    assign pop  = fifo_valid && out_ready;
    assign used = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, pop};

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        rd_issue = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start && (cmd_block < NBLK)) state_d = S_LOAD;
            end
            // Extra LOAD cycle after the last word lets its write retire before RUN.
            S_LOAD: begin
                in_ready = !full_q;
                if (full_q) state_d = S_RUN;
            end
            S_RUN:  state_d = S_WAIT;
            S_WAIT: begin
                if (ph_done) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                rd_issue = !rd_all_q && (used < 3'd2);
                if (pop && (ocnt_q == LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            ocnt_q    <= '0;
            wr_addr_q <= '0;
            blk_q     <= '0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            full_q    <= 1'b0;
            rd_all_q  <= 1'b0;
            infl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            infl_q  <= rd_issue;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_block < NBLK) begin
                            blk_q    <= cmd_block;
                            busy_q   <= 1'b1;
                            wcnt_q   <= '0;
                            rcnt_q   <= '0;
                            ocnt_q   <= '0;
                            full_q   <= 1'b0;
                            rd_all_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wcnt_q;
                        din_q     <= in_data;
                        if (wcnt_q == LAST) full_q <= 1'b1;
                        else wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (rd_issue) begin
                        if (rcnt_q == LAST) rd_all_q <= 1'b1;
                        else rcnt_q <= rcnt_q + 1'b1;
                    end
                    if (pop) begin
                        if (ocnt_q == LAST) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            ocnt_q <= ocnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sysz_skid_fifo #(.DW(W)) u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (infl_q),
        .din_i   (ph_rd_data),
        .pop_i   (pop),
        .dout_o  (out_data),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_block      = err_q;
    assign out_valid      = fifo_valid;
    assign out_last       = fifo_valid && (ocnt_q == LAST);
    assign ph_start       = (state_q == S_RUN);
    assign ph_start_block = blk_q;
    assign ph_pk_wr_en    = wr_en_q;
    assign ph_pk_wr_addr  = wr_addr_q;
    assign ph_pk_din      = din_q;
    assign ph_rd_en       = rd_issue;
    assign ph_rd_addr     = rcnt_q;

endmodule

// File: tb/tb_systemizer_ctrl.sv
// Directed bench for systemizer_ctrl with a simple echoing engine model.
// Monitors log writes and pops on the falling edge; tasks check deltas.
module tb_systemizer_ctrl;
    import systemizer_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic [BW-1:0] cmd_block = '0;
    logic          busy, done, err_block;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          ph_start;
    logic [BW-1:0] ph_start_block;
    logic          ph_done;
    logic          ph_pk_wr_en;
    logic [AW-1:0] ph_pk_wr_addr;
    logic [W-1:0]  ph_pk_din;
    logic          ph_rd_en;
    logic [AW-1:0] ph_rd_addr;
    logic [W-1:0]  ph_rd_data = '0;

    int total = 0;
    int bad = 0;

    systemizer_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_start      (cmd_start),
        .cmd_block      (cmd_block),
        .busy           (busy),
        .done           (done),
        .err_block      (err_block),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .ph_start       (ph_start),
        .ph_start_block (ph_start_block),
        .ph_done        (ph_done),
        .ph_pk_wr_en    (ph_pk_wr_en),
        .ph_pk_wr_addr  (ph_pk_wr_addr),
        .ph_pk_din      (ph_pk_din),
        .ph_rd_en       (ph_rd_en),
        .ph_rd_addr     (ph_rd_addr),
        .ph_rd_data     (ph_rd_data)
    );

    always #5 clk = !clk;

    // Engine model: memory echo, done pulse 5 cycles after start.
    logic [W-1:0] mem [WORDS];
    logic         eng_done = 1'b0;
    logic         tb_done = 1'b0;
    logic         eng_hold = 1'b0;
    int           eng_cnt = 0;
    int           cyc_n = 0;

    assign ph_done = eng_done | tb_done;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (ph_pk_wr_en) mem[ph_pk_wr_addr] <= ph_pk_din;
        if (ph_rd_en) ph_rd_data <= mem[ph_rd_addr];
        eng_done <= 1'b0;
        if (rst) begin
            eng_cnt <= 0;
        end else if (ph_start) begin
            eng_cnt <= 5;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_hold) eng_done <= 1'b1;
        end
    end

    int wr_a[$];
    int wr_d[$];
    int out_d[$];
    int out_l[$];
    int pop_t[$];
    int nstart = 0;
    int ndone = 0;
    int nerr = 0;
    int viol = 0;
    int last_blk = 0;

    always @(negedge clk) begin
        if (ph_pk_wr_en) begin
            wr_a.push_back(int'(ph_pk_wr_addr));
            wr_d.push_back(int'(ph_pk_din));
        end
        if (out_valid && out_ready) begin
            out_d.push_back(int'(out_data));
            out_l.push_back(int'(out_last));
            pop_t.push_back(cyc_n);
        end
        if (ph_start) begin
            nstart   <= nstart + 1;
            last_blk <= int'(ph_start_block);
        end
        if (done) ndone <= ndone + 1;
        if (err_block) nerr <= nerr + 1;
        if (ph_pk_wr_en && ph_rd_en) viol <= viol + 1;
        if (ph_start && (ph_pk_wr_en || ph_rd_en)) viol <= viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full load-run-drain; rdy=1 randomises out_ready; abrt resets in WAIT.
    task automatic do_sequence(input int blk, input int gap, input int rdy,
                               input int seed, input int spur, input int abrt);
        int w0, o0, s0, d0, idx, cyc, hl, e;
        bit held, fired;
        w0 = wr_a.size(); o0 = out_d.size(); s0 = nstart; d0 = ndone;
        cmd_start = 1'b1;
        cmd_block = BW'(blk);
        tick();
        cmd_start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_on: got %b want 1", busy);
        end
        idx = 0; cyc = 0;
        while (idx < WORDS && cyc < 500) begin
            in_valid = (gap == 0) ? 1'b1 : ((cyc % 2) == 0);
            in_data  = W'(idx + seed);
            tb_done  = (spur != 0 && cyc == 3);
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        tb_done  = 1'b0;
        total++;
        if (idx != WORDS) begin
            bad++; $display("FAIL load_timeout: got %0d want %0d", idx, WORDS);
        end
        if (abrt != 0) begin
            cyc = 0;
            while (nstart == s0 && cyc < 100) begin tick(); cyc++; end
            repeat (3) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            total++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || ph_start !== 1'b0) begin
                bad++;
                $display("FAIL abort_outputs: got %b%b%b want 000", busy, out_valid, ph_start);
            end
            repeat (10) tick();
            total++;
            if (nstart - s0 != 1 || ndone != d0) begin
                bad++;
                $display("FAIL abort_quiet: got starts=%0d dones=%0d want 1 0",
                         nstart - s0, ndone - d0);
            end
            return;
        end
        cyc = 0; hl = 0; held = 0; fired = 0;
        while (ndone == d0 && cyc < 2000) begin
            cmd_start = 1'b0;
            if (spur != 0 && !fired && out_d.size() - o0 >= 5) begin
                cmd_start = 1'b1;
                cmd_block = BW'(1);
                fired = 1;
            end
            if (rdy != 0 && !held && out_d.size() - o0 >= 12) begin
                hl = 10; held = 1;
            end
            if (rdy == 0) out_ready = 1'b1;
            else if (hl > 0) begin out_ready = 1'b0; hl--; end
            else out_ready = ($urandom % 2) == 1;
            tick();
            cyc++;
        end
        cmd_start = 1'b0;
        out_ready = 1'b1;
        total++;
        if (ndone - d0 != 1) begin
            bad++; $display("FAIL done_count: got %0d want 1", ndone - d0);
        end
        total++;
        if (wr_a.size() - w0 != WORDS) begin
            bad++; $display("FAIL write_count: got %0d want %0d", wr_a.size() - w0, WORDS);
        end else begin
            e = 0;
            for (int i = 0; i < WORDS; i++)
                if (wr_a[w0 + i] != i || wr_d[w0 + i] != ((i + seed) % 16)) e++;
            total++;
            if (e != 0) begin
                bad++; $display("FAIL write_seq: got %0d bad words want 0", e);
            end
        end
        total++;
        if (nstart - s0 != 1 || last_blk != blk) begin
            bad++;
            $display("FAIL ph_start: got n=%0d blk=%0d want 1 %0d", nstart - s0, last_blk, blk);
        end
        total++;
        if (out_d.size() - o0 != WORDS) begin
            bad++; $display("FAIL out_count: got %0d want %0d", out_d.size() - o0, WORDS);
        end else begin
            e = 0;
            for (int i = 0; i < WORDS; i++) begin
                if (out_d[o0 + i] != ((i + seed) % 16)) e++;
                if (out_l[o0 + i] != ((i == WORDS - 1) ? 1 : 0)) e++;
            end
            total++;
            if (e != 0) begin
                bad++; $display("FAIL out_seq: got %0d errors want 0", e);
            end
            if (rdy == 0) begin
                total++;
                if (pop_t[o0 + WORDS - 1] - pop_t[o0] != WORDS - 1) begin
                    bad++;
                    $display("FAIL throughput: got %0d cycles want %0d",
                             pop_t[o0 + WORDS - 1] - pop_t[o0], WORDS - 1);
                end
            end
        end
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || wr_a.size() - w0 != WORDS) begin
            bad++;
            $display("FAIL post_idle: got busy=%b in_ready=%b writes=%0d want 0 0 %0d",
                     busy, in_ready, wr_a.size() - w0, WORDS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({busy, done, err_block, in_ready, out_valid, out_last, ph_start,
             ph_pk_wr_en, ph_rd_en} !== 9'b0) begin
            bad++; $display("FAIL reset_ctl: got nonzero control outputs");
        end
        total++;
        if (ph_start_block !== '0 || ph_pk_wr_addr !== '0 || ph_pk_din !== '0 ||
            ph_rd_addr !== '0 || out_data !== '0) begin
            bad++; $display("FAIL reset_data: got nonzero data outputs");
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got busy=%b in_ready=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        do_sequence(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_err_block();
        int e0, s0, w0;
        e0 = nerr; s0 = nstart; w0 = wr_a.size();
        cmd_start = 1'b1;
        cmd_block = BW'(4);
        tick();
        cmd_start = 1'b0;
        total++;
        if (err_block !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL err_pulse: got err=%b busy=%b want 1 0", err_block, busy);
        end
        tick();
        total++;
        if (err_block !== 1'b0) begin
            bad++; $display("FAIL err_width: got %b want 0", err_block);
        end
        cmd_start = 1'b1;
        cmd_block = BW'(7);
        tick();
        cmd_start = 1'b0;
        repeat (6) tick();
        total++;
        if (nerr - e0 != 2 || nstart != s0 || wr_a.size() != w0 ||
            busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL err_quiet: got errs=%0d starts=%0d writes=%0d want 2 0 0",
                     nerr - e0, nstart - s0, wr_a.size() - w0);
        end
    endtask

    task automatic test_gaps();
        do_sequence(1, 1, 0, 5, 0, 0);
    endtask

    task automatic test_backpressure();
        do_sequence(3, 0, 1, 9, 0, 0);
    endtask

    task automatic test_reset_wait();
        eng_hold = 1'b1;
        do_sequence(1, 0, 0, 3, 0, 1);
        eng_hold = 1'b0;
        do_sequence(2, 0, 0, 7, 0, 0);
    endtask

    task automatic test_ignored();
        do_sequence(0, 0, 1, 11, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err_block();
        test_gaps();
        test_backpressure();
        test_reset_wait();
        test_ignored();
        total++;
        if (viol != 0) begin
            bad++; $display("FAIL port_exclusive: got %0d violations want 0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
